vga_stream_out: RTL

- Raster output stage that drives the VGA conduit (HS, VS, BLANK, SYNC, 4-bit R/G/B) of the pong system.
- Generates 640x480@60 timing from a 25 MHz pixel clock.
- Pulls pixels from the upstream frame-fetch/render stage over a valid/ready stream with start-of-packet framing.
- Resynchronises to the upstream frame on underflow or misalignment.

---
 rtl/vga_stream_out.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_stream_out.sv
// VGA raster output stage: 640x480@60 timing fed by a valid/ready pixel stream with SOP framing.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds the test_mode input).
module vga_stream_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 4,
    parameter logic [3*COLOR_W-1:0] UFLOW_RGB = 12'hF0F
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3*COLOR_W-1:0]   pix_data,
    input  logic                   pix_valid,
    input  logic                   pix_sop,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                   test_mode,
`endif
    output logic                   pix_ready,
    output logic                   vga_hs_n,
    output logic                   vga_vs_n,
    output logic                   vga_blank_n,
    output logic                   vga_sync_n,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   frame_start,
    output logic                   underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = 3 * COLOR_W;

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {SEEK, ARMED, STREAM, FLUSH} state_t;

    state_t        state, next_state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, at_origin, frame_end, set_uflow;
    logic [PW-1:0] rgb_p0;

    assign active     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
    assign frame_end  = (h_cnt == H_LAST_C) && (v_cnt == V_LAST_C);
    assign vga_sync_n = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    // Bar order white..black maps onto the index bits as R=~b1, G=~b2, B=~b0.
    logic [2:0]    bar_idx;
    logic [PW-1:0] bar_rgb;
    assign bar_idx = 3'(int'(h_cnt) / (H_ACTIVE / 8));
    assign bar_rgb = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}}, {COLOR_W{~bar_idx[0]}}};
`endif

    always_comb begin
        next_state = state;
        pix_ready  = 1'b0;
        rgb_p0     = '0;
        set_uflow  = 1'b0;
        case (state)
            SEEK: begin
                pix_ready = !(pix_valid && pix_sop);
                if (pix_valid && pix_sop) next_state = ARMED;
            end
            ARMED: begin
                if (at_origin) begin
                    pix_ready = 1'b1;
                    if (pix_valid) begin
                        rgb_p0     = pix_data;
                        next_state = STREAM;
                    end else begin
                        rgb_p0     = UFLOW_RGB;
                        set_uflow  = 1'b1;
                        next_state = FLUSH;
                    end
                end
            end
            STREAM: begin
                // Valid is checked before SOP; a misaligned SOP is left in the stream.
                if (active) begin
                    if (!pix_valid) begin
                        pix_ready  = 1'b1;
                        rgb_p0     = UFLOW_RGB;
                        set_uflow  = 1'b1;
                        next_state = FLUSH;
                    end else if (pix_sop && !at_origin) begin
                        next_state = ARMED;
                    end else if (!pix_sop && at_origin) begin
                        next_state = SEEK;
                    end else begin
                        pix_ready = 1'b1;
                        rgb_p0    = pix_data;
                    end
                end
            end
            FLUSH: begin
                if (active) rgb_p0 = UFLOW_RGB;
                if (frame_end) next_state = SEEK;
            end
            default: next_state = SEEK;
        endcase
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            pix_ready  = 1'b0;
            set_uflow  = 1'b0;
            next_state = SEEK;
            rgb_p0     = active ? bar_rgb : '0;
        end
`endif
    end

    // Output register stage: everything below is one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt                 <= '0;
            v_cnt                 <= '0;
            state                 <= SEEK;
            underflow             <= 1'b0;
            vga_hs_n              <= 1'b1;
            vga_vs_n              <= 1'b1;
            vga_blank_n           <= 1'b0;
            {vga_r, vga_g, vga_b} <= '0;
            frame_start           <= 1'b0;
        end else begin
            state <= next_state;
            if (h_cnt == H_LAST_C) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            vga_hs_n              <= !((h_cnt >= H_SS_C) && (h_cnt < H_SE_C));
            vga_vs_n              <= !((v_cnt >= V_SS_C) && (v_cnt < V_SE_C));
            vga_blank_n           <= active;
            {vga_r, vga_g, vga_b} <= rgb_p0;
            frame_start           <= at_origin;
            underflow             <= underflow | set_uflow;
        end
    end

endmodule
